// File: rtl/card_digit_feeder.sv
// card_digit_feeder: validates an ASCII card-number frame, buffers its digits
// and replays a good frame as one contiguous NUM_DIGITS-long digit burst.
// Build option: FEEDER_SEP_FILTER_EN lets ' ' and '-' through as separators.
// Ports: clk, rst_n (async, active-low); char_in/char_valid/char_last/char_ready
//   upstream valid/ready stream; digit_out/digit_valid burst output;
//   err/err_code reject pulse; frame_cnt counts emitted frames.
module card_digit_feeder #(
  parameter int NUM_DIGITS  = 15,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  input  logic                   char_last,
  output logic                   char_ready,
  output logic [3:0]             digit_out,
  output logic                   digit_valid,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_BAD   = 2'b01;
  localparam logic [1:0] E_SHORT = 2'b10;
  localparam logic [1:0] E_LONG  = 2'b11;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_BURST,
    S_GAP
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [CW-1:0]          idx_q;
  logic [1:0]             lat_q;
  logic [1:0]             lat_d;
  logic [1:0]             code_d;
  logic [3:0]             buf_q [NUM_DIGITS];
  logic                   ready_q;
  logic [3:0]             dout_q;
  logic                   dvalid_q;
  logic                   err_q;
  logic [1:0]             ecode_q;
  logic [FRAME_CNT_W-1:0] fcnt_q;

  logic       acc_d;
  logic       is_dig_d;
  logic       is_sep_d;
  logic       full_d;
  logic       store_d;
  logic       good_d;
  logic [3:0] first_d;

  always_comb begin
    acc_d    = char_valid && ready_q;
    is_dig_d = (char_in >= 8'h30) && (char_in <= 8'h39);
`ifdef FEEDER_SEP_FILTER_EN
    is_sep_d = (char_in == 8'h20) || (char_in == 8'h2D);
`else
    is_sep_d = 1'b0;
`endif
    full_d  = (cnt_q == FULL);
    store_d = acc_d && is_dig_d && !full_d;
    cnt_d   = store_d ? cnt_q + 1'b1 : cnt_q;
    code_d  = E_NONE;
    unique case (1'b1)
      is_dig_d: code_d = full_d ? E_LONG : E_NONE;
      is_sep_d: code_d = E_NONE;
      default:  code_d = E_BAD;
    endcase
    // first error of the frame wins
    lat_d  = (lat_q != E_NONE) ? lat_q : code_d;
    good_d = (lat_d == E_NONE) && (cnt_d == FULL);
    // a one-digit frame writes buf[0] on the same edge the burst starts
    first_d = (store_d && cnt_q == '0) ? char_in[3:0] : buf_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= 4'd0;
      end
    end else if (store_d) begin
      buf_q[cnt_q] <= char_in[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_COLLECT;
      cnt_q    <= '0;
      idx_q    <= '0;
      lat_q    <= E_NONE;
      ready_q  <= 1'b1;
      dout_q   <= 4'd0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      ecode_q  <= E_NONE;
      fcnt_q   <= '0;
    end else begin
      err_q   <= 1'b0;
      ecode_q <= E_NONE;
      unique case (state_q)
        S_COLLECT: begin
          if (acc_d && char_last) begin
            cnt_q <= '0;
            lat_q <= E_NONE;
            if (good_d) begin
              state_q  <= S_BURST;
              ready_q  <= 1'b0;
              dvalid_q <= 1'b1;
              dout_q   <= first_d;
              idx_q    <= CW'(1);
            end else begin
              err_q   <= 1'b1;
              ecode_q <= (lat_d != E_NONE) ? lat_d : E_SHORT;
            end
          end else if (acc_d) begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
          end
        end
        S_BURST: begin
          if (idx_q == FULL) begin
            state_q  <= S_GAP;
            dvalid_q <= 1'b0;
            dout_q   <= 4'd0;
            fcnt_q   <= fcnt_q + 1'b1;
          end else begin
            dout_q <= buf_q[idx_q];
            idx_q  <= idx_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q <= S_COLLECT;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_COLLECT;
        end
      endcase
    end
  end

  assign char_ready  = ready_q;
  assign digit_out   = dout_q;
  assign digit_valid = dvalid_q;
  assign err         = err_q;
  assign err_code    = ecode_q;
  assign frame_cnt   = fcnt_q;

endmodule
